lcd_responder: RTL and testbench
================================

# lcd_responder

HD44780-style character-LCD responder for the rob_processor display path. It sits on the LCD side of the E/RS/RW/DB[7:0] bus and decodes instructions and data writes. It holds a 2x16 character buffer, drives the busy flag and address counter on reads, and exposes a read port so a display mirror or a bench checker can inspect the screen contents.

## Interface
- BUSY_CMD, default 3: busy cycles after a data write or a non-clear/home instruction (≥1).
- BUSY_CLR, default 8: busy cycles after home, and after the 32-cycle fill for clear/reset (≥1).
- clk  in  1  single clock; all bus inputs are synchronous to it.
- rst  in  1  asynchronous, active-low reset.
- lcd_e  in  1  enable strobe; actions occur on the falling edge.
- lcd_rs  in  1  0 = instruction/status, 1 = data.
- lcd_rw  in  1  0 = write, 1 = read.
- lcd_db_in  in  8  bus data from the initiator.
- lcd_db_out  out  8  read data.
- lcd_db_oe  out  1  read-drive enable.
- rd_addr  in  5  buffer index (0-15 = line 0, 16-31 = line 1).
- rd_data  out  8  buffer byte; registered, 1-cycle latency.
- busy  out  1  busy flag.
- disp_on, cursor_on, blink_on  out  1 each  display-control state.
- entry_inc, entry_shift  out  1 each  entry-mode state.
- err  out  1  one-cycle pulse on a rejected or unsupported access.

## Operation
- **Falling-edge detection.** e_q is lcd_e registered. A fall is the cycle where e_q=1 and lcd_e=0. RS, RW and DB are sampled in that same cycle.
- **Acceptance.** A fall is accepted only if busy (the registered value) is 0.
  - A write fall while busy=1 is dropped and pulses err.
  - A read fall is always accepted.
- **Address counter (AC, 7 bits).**
  - Visible window: 0x00-0x0F maps to index 0-15; 0x40-0x4F maps to index 16-31.
  - Increment wraps 0x27 to 0x40 and 0x67 to 0x00. Decrement is the reverse.
  - Writes outside the visible window are not stored, but AC still advances.
- **Instruction decode (RS=0, RW=0).** The highest set bit selects the instruction.
  - 1aaaaaaa: AC <= a.
  - 01xxxxxx (CGRAM): ignored, err pulse.
  - 001xxxxx (function set): accepted, no effect.
  - 0001xxxx (shift): ignored, err pulse.
  - 00001DCB: disp_on, cursor_on, blink_on <= D, C, B.
  - 000001IS: entry_inc, entry_shift <= I, S. entry_shift is stored only.
  - 0000001x (home): AC <= 0; busy for BUSY_CLR cycles.
  - 00000001 (clear): AC <= 0, entry_inc <= 1, go to FILL.
  - 00000000: err pulse, no effect.
- **Data write (RS=1, RW=0).** buffer[map(AC)] <= DB, then AC is incremented or decremented per entry_inc.
- **Read (RW=1).**
  - lcd_db_oe <= lcd_rw & lcd_e, registered.
  - RS=0 drives {busy, AC}.
  - RS=1 drives buffer[map(AC)], or 0x20 outside the window.
  - On an RS=1 read fall, AC advances.
- **State machine: IDLE, BUSY, FILL.**
  - IDLE: an accepted busy-causing fall goes to BUSY, with timer <= n-1.
  - IDLE: an accepted clear goes to FILL, with idx <= 0.
  - BUSY: the timer decrements each cycle; when timer==0, busy <= 0 and the state returns to IDLE.
  - FILL: writes 0x20 to buffer[idx] each cycle for idx 0..31, then goes to BUSY with timer <= BUSY_CLR-1.
  - busy is 1 in BUSY and in FILL.
- **Reset values.**
  - state FILL, idx 0, busy 1, AC 0.
  - disp_on, cursor_on, blink_on 0; entry_inc 1; entry_shift 0.
  - lcd_db_out 0x00, lcd_db_oe 0, rd_data 0x00, err 0, e_q 0.
  - Reset mid-operation aborts immediately and restarts FILL.

## Timing
- An accepted fall at edge N updates AC, the flags and the buffer at edge N; busy reads 1 from N+1.
- For a fall with busy period n, busy is sampled as 1 at edges N+1..N+n, and the next write fall is accepted at edge N+n+1 or later.
- With BUSY_CMD=3, one write per 4 cycles is sustained.
- Clear: busy for 32+BUSY_CLR cycles. After reset deassertion: busy for 32+BUSY_CLR cycles.
- A write fall in the same cycle that busy drops is rejected, because the registered busy is still 1.
- rd_data is read-before-write: a bus write and an rd_addr read to the same index in one cycle return the old byte, and the new byte on the next read.
- lcd_db_out and lcd_db_oe follow the bus inputs by 1 cycle.

## Structure
- lcd_pkg holds:
  - opcode masks;
  - LINE1_BASE=0x40, LINE_LEN=16, WRAP0=0x27, WRAP1=0x67, SPACE=0x20;
  - the state enum.
- Sub-module lcd_char_ram: 32x8 storage with one synchronous write port and two registered read ports (bus read and rd_addr).
- Address mapping and the state machine live in lcd_responder.

## Test plan
- **Reset then clear.** Release reset; poll busy -> busy=1 for 40 cycles (32+BUSY_CLR=8), then 0. All 32 rd_data reads return 0x20.
- **Data writes.** Send 0xC0, wait, then write 0x31 and 0x30 at a 4-cycle pace -> index 16=0x31, 17=0x30, AC=0x42, err never pulses.
- **Write while busy.** Write 0x41, then a second write 2 cycles after the first fall -> second write dropped, err pulses once, AC advanced by 1 only.
- **AC wrap.** Set AC=0x27 and write -> AC=0x40, nothing stored. Set entry_inc=0, AC=0x00 and write -> AC=0x67.
- **Status read.** With RW=1, RS=0, E high during FILL -> lcd_db_out bit7=1 and lcd_db_oe=1 one cycle after E rises. A read during IDLE at AC=0x05 -> 0x05.
- **Reset mid-FILL.** Assert rst at idx=10 -> outputs return to reset values asynchronously, and the fill restarts at idx 0 after release.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared constants, opcode masks, state/opcode enums and address-counter helpers
// for the character-LCD responder.
package lcd_pkg;

  localparam logic [6:0] LINE1_BASE = 7'h40;
  localparam int         LINE_LEN   = 16;
  localparam logic [6:0] WRAP0      = 7'h27;
  localparam logic [6:0] WRAP1      = 7'h67;
  localparam logic [7:0] SPACE      = 8'h20;

  localparam logic [7:0] OP_SETDD_MASK = 8'h80;
  localparam logic [7:0] OP_CGRAM_MASK = 8'h40;
  localparam logic [7:0] OP_FUNC_MASK  = 8'h20;
  localparam logic [7:0] OP_SHIFT_MASK = 8'h10;
  localparam logic [7:0] OP_DISP_MASK  = 8'h08;
  localparam logic [7:0] OP_ENTRY_MASK = 8'h04;
  localparam logic [7:0] OP_HOME_MASK  = 8'h02;
  localparam logic [7:0] OP_CLEAR_MASK = 8'h01;

  typedef enum logic [1:0] {IDLE, BUSY, FILL} lcdState_t;

  typedef enum logic [3:0] {
    OP_NONE, OP_SETDD, OP_CGRAM, OP_FUNC, OP_SHIFT,
    OP_DISP, OP_ENTRY, OP_HOME, OP_CLEAR
  } lcdOp_t;

  // The highest set bit of the instruction byte picks the opcode.
  function automatic lcdOp_t opDecode(input logic [7:0] db);
    if ((db & OP_SETDD_MASK) != 8'h00) return OP_SETDD;
    if ((db & OP_CGRAM_MASK) != 8'h00) return OP_CGRAM;
    if ((db & OP_FUNC_MASK)  != 8'h00) return OP_FUNC;
    if ((db & OP_SHIFT_MASK) != 8'h00) return OP_SHIFT;
    if ((db & OP_DISP_MASK)  != 8'h00) return OP_DISP;
    if ((db & OP_ENTRY_MASK) != 8'h00) return OP_ENTRY;
    if ((db & OP_HOME_MASK)  != 8'h00) return OP_HOME;
    if ((db & OP_CLEAR_MASK) != 8'h00) return OP_CLEAR;
    return OP_NONE;
  endfunction

  function automatic logic [6:0] acStep(input logic [6:0] ac, input logic inc);
    if (inc) begin
      if (ac == WRAP0) return LINE1_BASE;
      if (ac == WRAP1) return 7'h00;
      return ac + 7'd1;
    end
    if (ac == LINE1_BASE) return WRAP0;
    if (ac == 7'h00)      return WRAP1;
    return ac - 7'd1;
  endfunction

  function automatic logic acInWindow(input logic [6:0] ac);
    return ac[5:4] == 2'b00;
  endfunction

  function automatic logic [4:0] acIndex(input logic [6:0] ac);
    return {ac[6], ac[3:0]};
  endfunction

endpackage

// File: rtl/lcd_if.sv
// LCD-side E/RS/RW/DB bus; the initiator is the master, the responder the slave.
interface lcd_if;
  logic       lcd_e;
  logic       lcd_rs;
  logic       lcd_rw;
  logic [7:0] lcd_db_in;
  logic [7:0] lcd_db_out;
  logic       lcd_db_oe;

  modport master (output lcd_e, lcd_rs, lcd_rw, lcd_db_in,
                  input  lcd_db_out, lcd_db_oe);
  modport slave  (input  lcd_e, lcd_rs, lcd_rw, lcd_db_in,
                  output lcd_db_out, lcd_db_oe);
endinterface

// File: rtl/lcd_char_ram.sv
// 32x8 character buffer: one synchronous write port, two registered read ports
// (bus readback and the external inspection port). Reads return the old byte.
module lcd_char_ram (
  input  logic       clk,
  input  logic       we,
  input  logic [4:0] wrAddr,
  input  logic [7:0] wrData,
  input  logic [4:0] busAddr,
  output logic [7:0] busData,
  input  logic [4:0] rdAddr,
  output logic [7:0] rdData
);
  logic [7:0] mem [32];
  logic [4:0] portAddr [2];
  logic [7:0] portData [2];

  assign portAddr[0] = busAddr;
  assign portAddr[1] = rdAddr;

  always_ff @(posedge clk) begin
    if (we) mem[wrAddr] <= wrData;
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd
      logic [7:0] q;
      always_ff @(posedge clk) q <= mem[portAddr[gi]];
      assign portData[gi] = q;
    end
  endgenerate

  assign busData = portData[0];
  assign rdData  = portData[1];
endmodule

// File: rtl/lcd_responder.sv
// HD44780-style responder: decodes E falling edges into instructions/data
// writes, runs the IDLE/BUSY/FILL sequencer and serves status and data reads.
module lcd_responder
  import lcd_pkg::*;
#(
  parameter int BUSY_CMD = 3,
  parameter int BUSY_CLR = 8
) (
  input  logic       clk,
  input  logic       rst,
  lcd_if.slave       bus,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic       disp_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       entry_inc,
  output logic       entry_shift,
  output logic       err
);
  localparam int TMAX = (BUSY_CMD > BUSY_CLR) ? BUSY_CMD : BUSY_CLR;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] T_CMD = TW'(BUSY_CMD - 1);
  localparam logic [TW-1:0] T_CLR = TW'(BUSY_CLR - 1);
  localparam logic [4:0]    IDX_LAST = 5'(2 * LINE_LEN - 1);

  lcdState_t     stateReg, stateNext;
  logic [TW-1:0] timerReg, timerNext;
  logic [4:0]    idxReg, idxNext;
  logic [6:0]    acReg, acNext;
  logic          dispOnReg, dispOnNext, cursorOnReg, cursorOnNext;
  logic          blinkOnReg, blinkOnNext, entryIncReg, entryIncNext;
  logic          entryShiftReg, entryShiftNext, errReg, errNext;
  logic          eQReg, oeReg, rsQReg, winQReg, rdValidReg;
  logic [7:0]    statusReg;

  logic       ramWe;
  logic [4:0] ramWrAddr;
  logic [7:0] ramWrData, ramBusData, ramRdData;

  logic   fall, wrFall, rdFall, busyNow;
  lcdOp_t op;

  assign busyNow = (stateReg != IDLE);
  assign fall    = eQReg & ~bus.lcd_e;
  assign wrFall  = fall & ~bus.lcd_rw;
  assign rdFall  = fall & bus.lcd_rw;
  assign op      = opDecode(bus.lcd_db_in);

  lcd_char_ram u_ram (
    .clk     (clk),
    .we      (ramWe),
    .wrAddr  (ramWrAddr),
    .wrData  (ramWrData),
    .busAddr (acIndex(acReg)),
    .busData (ramBusData),
    .rdAddr  (rd_addr),
    .rdData  (ramRdData)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateReg      <= FILL;
      timerReg      <= '0;
      idxReg        <= '0;
      acReg         <= '0;
      dispOnReg     <= 1'b0;
      cursorOnReg   <= 1'b0;
      blinkOnReg    <= 1'b0;
      entryIncReg   <= 1'b1;
      entryShiftReg <= 1'b0;
      errReg        <= 1'b0;
      eQReg         <= 1'b0;
      oeReg         <= 1'b0;
      rsQReg        <= 1'b0;
      winQReg       <= 1'b0;
      rdValidReg    <= 1'b0;
      statusReg     <= 8'h00;
    end else begin
      stateReg      <= stateNext;
      timerReg      <= timerNext;
      idxReg        <= idxNext;
      acReg         <= acNext;
      dispOnReg     <= dispOnNext;
      cursorOnReg   <= cursorOnNext;
      blinkOnReg    <= blinkOnNext;
      entryIncReg   <= entryIncNext;
      entryShiftReg <= entryShiftNext;
      errReg        <= errNext;
      eQReg         <= bus.lcd_e;
      oeReg         <= bus.lcd_rw & bus.lcd_e;
      rsQReg        <= bus.lcd_rs;
      winQReg       <= acInWindow(acReg);
      rdValidReg    <= 1'b1;
      statusReg     <= {busyNow, acReg};
    end
  end

  always_comb begin
    stateNext      = stateReg;
    timerNext      = timerReg;
    idxNext        = idxReg;
    acNext         = acReg;
    dispOnNext     = dispOnReg;
    cursorOnNext   = cursorOnReg;
    blinkOnNext    = blinkOnReg;
    entryIncNext   = entryIncReg;
    entryShiftNext = entryShiftReg;
    errNext        = 1'b0;
    ramWe          = 1'b0;
    ramWrAddr      = idxReg;
    ramWrData      = SPACE;

    case (stateReg)
      FILL: begin
        ramWe   = 1'b1;
        idxNext = idxReg + 5'd1;
        if (idxReg == IDX_LAST) begin
          stateNext = BUSY;
          timerNext = T_CLR;
        end
      end
      BUSY: begin
        if (timerReg == '0) stateNext = IDLE;
        else                timerNext = timerReg - TW'(1);
      end
      default: ;
    endcase

    if (wrFall && busyNow) errNext = 1'b1;

    // Accepted writes only happen in IDLE, so they never collide with FILL.
    if (wrFall && !busyNow) begin
      if (bus.lcd_rs) begin
        if (acInWindow(acReg)) begin
          ramWe     = 1'b1;
          ramWrAddr = acIndex(acReg);
          ramWrData = bus.lcd_db_in;
        end
        acNext    = acStep(acReg, entryIncReg);
        stateNext = BUSY;
        timerNext = T_CMD;
      end else begin
        case (op)
          OP_SETDD: begin
            acNext    = bus.lcd_db_in[6:0];
            stateNext = BUSY;
            timerNext = T_CMD;
          end
          OP_FUNC: begin
            stateNext = BUSY;
            timerNext = T_CMD;
          end
          OP_DISP: begin
            dispOnNext   = bus.lcd_db_in[2];
            cursorOnNext = bus.lcd_db_in[1];
            blinkOnNext  = bus.lcd_db_in[0];
            stateNext    = BUSY;
            timerNext    = T_CMD;
          end
          OP_ENTRY: begin
            entryIncNext   = bus.lcd_db_in[1];
            entryShiftNext = bus.lcd_db_in[0];
            stateNext      = BUSY;
            timerNext      = T_CMD;
          end
          OP_HOME: begin
            acNext    = 7'h00;
            stateNext = BUSY;
            timerNext = T_CLR;
          end
          OP_CLEAR: begin
            acNext       = 7'h00;
            entryIncNext = 1'b1;
            stateNext    = FILL;
            idxNext      = 5'd0;
          end
          default: errNext = 1'b1;
        endcase
      end
    end

    if (rdFall && bus.lcd_rs) acNext = acStep(acReg, entryIncReg);
  end

  assign bus.lcd_db_oe  = oeReg;
  assign bus.lcd_db_out = !rsQReg ? statusReg : (winQReg ? ramBusData : SPACE);
  assign rd_data        = rdValidReg ? ramRdData : 8'h00;
  assign busy           = busyNow;
  assign disp_on        = dispOnReg;
  assign cursor_on      = cursorOnReg;
  assign blink_on       = blinkOnReg;
  assign entry_inc      = entryIncReg;
  assign entry_shift    = entryShiftReg;
  assign err            = errReg;
endmodule

// File: tb/tb_lcd_responder.sv
// Directed bench for lcd_responder: reads are scoreboarded and checked by a
// monitor; control flags, busy timing and err pulses are checked inline.
module tb_lcd_responder;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] rd_addr = 5'd0;
  logic [7:0] rd_data;
  logic       busy, disp_on, cursor_on, blink_on, entry_inc, entry_shift, err;

  lcd_if bus();

  lcd_responder #(.BUSY_CMD(3), .BUSY_CLR(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .busy        (busy),
    .disp_on     (disp_on),
    .cursor_on   (cursor_on),
    .blink_on    (blink_on),
    .entry_inc   (entry_inc),
    .entry_shift (entry_shift),
    .err         (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] val;
  } exp_t;

  exp_t rdQ[$];
  exp_t busQ[$];
  int   checks = 0;
  int   errors = 0;
  int   errCount = 0;
  logic rdReq = 1'b0;
  logic rdReqQ = 1'b0;

  function automatic void checkv(input string name, input logic [31:0] act,
                                 input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endfunction

  always @(posedge clk) rdReqQ <= rdReq;

  // Monitor: pops an expectation whenever the DUT presents read data.
  always @(negedge clk) begin
    exp_t e;
    if (err === 1'b1) errCount++;
    if (rdReqQ) begin
      if (rdQ.size() == 0) begin
        checks++; errors++;
        $display("FAIL rd_data: unexpected read, got 0x%02h", rd_data);
      end else begin
        e = rdQ.pop_front();
        checkv(e.name, {24'h0, rd_data}, {24'h0, e.val});
      end
    end
    if (bus.lcd_db_oe === 1'b1) begin
      if (busQ.size() == 0) begin
        checks++; errors++;
        $display("FAIL lcd_db_out: unexpected drive, got 0x%02h", bus.lcd_db_out);
      end else begin
        e = busQ.pop_front();
        checkv(e.name, {24'h0, bus.lcd_db_out}, {24'h0, e.val});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic rs, input logic [7:0] d);
    bus.lcd_e = 1'b1; bus.lcd_rs = rs; bus.lcd_rw = 1'b0; bus.lcd_db_in = d;
    tick();
    bus.lcd_e = 1'b0;
    tick();
  endtask

  task automatic busRd(input logic rs, input logic [7:0] exp, input string name);
    busQ.push_back(exp_t'{name, exp});
    bus.lcd_e = 1'b1; bus.lcd_rs = rs; bus.lcd_rw = 1'b1;
    tick();
    bus.lcd_e = 1'b0;
    tick();
    bus.lcd_rw = 1'b0;
  endtask

  task automatic portRd(input logic [4:0] a, input logic [7:0] exp, input string name);
    rdQ.push_back(exp_t'{name, exp});
    rd_addr = a;
    rdReq = 1'b1;
    tick();
    rdReq = 1'b0;
  endtask

  task automatic waitIdle(output int cycles);
    cycles = 0;
    while (busy !== 1'b0 && cycles < 200) begin
      tick();
      cycles++;
    end
    if (busy !== 1'b0) begin
      checks++; errors++;
      $display("FAIL busy timeout: busy=%b after %0d cycles, required 0", busy, cycles);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkv({tag, " busy"},      {31'h0, busy},           32'h1);
    checkv({tag, " db_out"},    {24'h0, bus.lcd_db_out}, 32'h0);
    checkv({tag, " db_oe"},     {31'h0, bus.lcd_db_oe},  32'h0);
    checkv({tag, " rd_data"},   {24'h0, rd_data},        32'h0);
    checkv({tag, " err"},       {31'h0, err},            32'h0);
    checkv({tag, " disp flags"}, {29'h0, disp_on, cursor_on, blink_on}, 32'h0);
    checkv({tag, " entry"},     {30'h0, entry_inc, entry_shift}, 32'h2);
  endtask

  initial begin
    int cyc;
    int errBase;
    bus.lcd_e = 1'b0; bus.lcd_rs = 1'b0; bus.lcd_rw = 1'b0; bus.lcd_db_in = 8'h00;

    // Reset and power-on fill.
    repeat (3) tick();
    checkResetOutputs("reset");
    rst = 1'b1;
    waitIdle(cyc);
    checkv("power-on busy cycles", cyc, 40);
    for (int i = 0; i < 32; i++) portRd(5'(i), 8'h20, $sformatf("fill idx%0d", i));

    // Paced data writes on line 1.
    wr(1'b0, 8'hC0);
    waitIdle(cyc);
    wr(1'b1, 8'h31);
    tick(); tick();
    wr(1'b1, 8'h30);
    waitIdle(cyc);
    portRd(5'd16, 8'h31, "write idx16");
    portRd(5'd17, 8'h30, "write idx17");
    busRd(1'b0, 8'h42, "status ac after writes");
    checkv("no err on paced writes", errCount, 0);

    // Second write lands while busy.
    errBase = errCount;
    wr(1'b1, 8'h41);
    wr(1'b1, 8'h55);
    waitIdle(cyc);
    tick();
    checkv("err on busy write", errCount - errBase, 1);
    busRd(1'b0, 8'h43, "status ac after dropped write");
    portRd(5'd18, 8'h41, "kept write idx18");
    portRd(5'd19, 8'h20, "dropped write idx19");

    // Display control.
    wr(1'b0, 8'h0D);
    checkv("display flags", {29'h0, disp_on, cursor_on, blink_on}, 32'h5);
    waitIdle(cyc);

    // AC wrap up and down.
    wr(1'b0, 8'hA7);
    waitIdle(cyc);
    wr(1'b1, 8'h77);
    waitIdle(cyc);
    busRd(1'b0, 8'h40, "ac wrap 0x27->0x40");
    wr(1'b0, 8'h04);
    checkv("entry_inc cleared", {31'h0, entry_inc}, 32'h0);
    waitIdle(cyc);
    wr(1'b0, 8'h80);
    waitIdle(cyc);
    wr(1'b1, 8'h58);
    waitIdle(cyc);
    busRd(1'b0, 8'h67, "ac wrap 0x00->0x67");
    portRd(5'd0, 8'h58, "decrement write idx0");

    // Clear, status during fill, status and data reads in idle.
    wr(1'b0, 8'h01);
    busRd(1'b0, 8'h80, "status during fill");
    checkv("clear sets entry_inc", {31'h0, entry_inc}, 32'h1);
    waitIdle(cyc);
    portRd(5'd16, 8'h20, "cleared idx16");
    portRd(5'd0, 8'h20, "cleared idx0");
    wr(1'b0, 8'h85);
    waitIdle(cyc);
    wr(1'b1, 8'h4B);
    waitIdle(cyc);
    wr(1'b0, 8'h85);
    waitIdle(cyc);
    busRd(1'b0, 8'h05, "status idle ac5");
    busRd(1'b1, 8'h4B, "data read ac5");
    busRd(1'b0, 8'h06, "ac after data read");

    // Reset in the middle of a clear fill.
    wr(1'b0, 8'hCF);
    waitIdle(cyc);
    wr(1'b1, 8'h39);
    waitIdle(cyc);
    portRd(5'd31, 8'h39, "write idx31");
    wr(1'b0, 8'h0D);
    waitIdle(cyc);
    wr(1'b0, 8'h01);
    repeat (10) tick();
    rst = 1'b0;
    #1;
    checkResetOutputs("mid-fill reset");
    tick();
    rst = 1'b1;
    waitIdle(cyc);
    checkv("refill busy cycles", cyc, 40);
    portRd(5'd31, 8'h20, "refill idx31");
    portRd(5'd0, 8'h20, "refill idx0");

    repeat (3) tick();
    checkv("scoreboard drained", rdQ.size() + busQ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d errors so far", errors);
    $fatal(1, "watchdog");
  end
endmodule
